// File: rtl/frame_buffer_index_gen.sv
// Per-frame write-request handshake and write/read buffer index generator for NUM_BUFS
// SDRAM frame buffers, with freeze support and completed/dropped frame counters.
module frame_buffer_index_gen #(
   parameter int unsigned NUM_BUFS     = 4,
   parameter int unsigned IDX_W        = 2,
   parameter int unsigned ADDR_W       = 24,
   parameter int unsigned BASE_ADDR    = 0,
   parameter int unsigned FRAME_STRIDE = 2073600,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_vsync,
   input  logic              freeze,
   output logic              write_req,
   input  logic              write_req_ack,
   output logic [IDX_W-1:0]  write_addr_index,
   output logic [IDX_W-1:0]  read_addr_index,
   output logic [ADDR_W-1:0] write_base_addr,
   output logic [ADDR_W-1:0] read_base_addr,
   output logic              read_valid,
   output logic [CNT_W-1:0]  frame_count,
   output logic [CNT_W-1:0]  drop_count
);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StReq    = 2'd1;
   localparam logic [1:0] StActive = 2'd2;

   localparam logic [IDX_W-1:0]  LastIdx = IDX_W'(NUM_BUFS - 1);
   localparam logic [ADDR_W-1:0] BaseA   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] StrideA = ADDR_W'(FRAME_STRIDE);

   logic [1:0]       state_q, state_d;
   logic             vsync_q;
   logic [IDX_W-1:0] widx_q, widx_d;
   logic [IDX_W-1:0] ridx_q, ridx_d;
   logic             rvalid_q, rvalid_d;
   logic [CNT_W-1:0] fcnt_q, fcnt_d;
   logic [CNT_W-1:0] dcnt_q, dcnt_d;

   logic             vedge;
   logic [IDX_W-1:0] new_read;
   logic [IDX_W-1:0] next_w;

   // Compare-and-reset increment keeps wrap-around at NUM_BUFS, not 2**IDX_W.
   function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] i);
      return (i == LastIdx) ? '0 : i + 1'b1;
   endfunction

   always_comb begin
      state_d  = state_q;
      widx_d   = widx_q;
      ridx_d   = ridx_q;
      rvalid_d = rvalid_q;
      fcnt_d   = fcnt_q;
      dcnt_d   = dcnt_q;

      vedge    = frame_vsync & ~vsync_q;
      new_read = freeze ? ridx_q : widx_q;
      next_w   = inc_idx(widx_q);
      if (next_w == new_read) begin
         next_w = inc_idx(next_w);
      end

      case (state_q)
         StIdle: begin
            if (vedge) begin
               state_d = StReq;
            end
         end
         StReq: begin
            if (write_req_ack) begin
               state_d = StActive;
            end
            // A frame start while still waiting for ack is lost, even if ack arrives with it.
            if (vedge && (dcnt_q != '1)) begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         StActive: begin
            if (vedge) begin
               ridx_d   = new_read;
               widx_d   = next_w;
               fcnt_d   = fcnt_q + 1'b1;
               rvalid_d = rvalid_q | ~freeze;
               state_d  = StReq;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         vsync_q  <= 1'b0;
         widx_q   <= '0;
         ridx_q   <= LastIdx;
         rvalid_q <= 1'b0;
         fcnt_q   <= '0;
         dcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         vsync_q  <= frame_vsync;
         widx_q   <= widx_d;
         ridx_q   <= ridx_d;
         rvalid_q <= rvalid_d;
         fcnt_q   <= fcnt_d;
         dcnt_q   <= dcnt_d;
      end
   end

   // Gated by rst so a pending request is withdrawn in the cycle reset is applied.
   assign write_req        = (state_q == StReq) & ~rst;
   assign write_addr_index = widx_q;
   assign read_addr_index  = ridx_q;
   assign read_valid       = rvalid_q;
   assign frame_count      = fcnt_q;
   assign drop_count       = dcnt_q;
   assign write_base_addr  = BaseA + ADDR_W'(widx_q) * StrideA;
   assign read_base_addr   = BaseA + ADDR_W'(ridx_q) * StrideA;

endmodule

// File: tb/tb_frame_buffer_index_gen.sv
// Self-checking bench: two instances (4 buffers / 4-bit counters and 3 buffers / 16-bit
// counters) driven in parallel and compared against a frame-level reference model.
module tb_frame_buffer_index_gen;

   logic clk = 1'b0;
   logic rst, vs, frz, ack;

   logic        a_req, a_rv, b_req, b_rv;
   logic [1:0]  a_w, a_r, b_w, b_r;
   logic [23:0] a_wba, a_rba, b_wba, b_rba;
   logic [3:0]  a_fc, a_dc;
   logic [15:0] b_fc, b_dc;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   frame_buffer_index_gen #(
      .NUM_BUFS(4), .IDX_W(2), .ADDR_W(24), .BASE_ADDR(0), .FRAME_STRIDE(2073600), .CNT_W(4)
   ) u_dut_a (
      .clk(clk), .rst(rst), .frame_vsync(vs), .freeze(frz), .write_req(a_req),
      .write_req_ack(ack), .write_addr_index(a_w), .read_addr_index(a_r),
      .write_base_addr(a_wba), .read_base_addr(a_rba), .read_valid(a_rv),
      .frame_count(a_fc), .drop_count(a_dc)
   );

   frame_buffer_index_gen #(
      .NUM_BUFS(3), .IDX_W(2), .ADDR_W(24), .BASE_ADDR(0), .FRAME_STRIDE(2073600), .CNT_W(16)
   ) u_dut_b (
      .clk(clk), .rst(rst), .frame_vsync(vs), .freeze(frz), .write_req(b_req),
      .write_req_ack(ack), .write_addr_index(b_w), .read_addr_index(b_r),
      .write_base_addr(b_wba), .read_base_addr(b_rba), .read_valid(b_rv),
      .frame_count(b_fc), .drop_count(b_dc)
   );

   // Reference model: phase 0 = no frame, 1 = awaiting ack, 2 = frame being written.
   int m_ph[2], m_w[2], m_r[2], m_rv[2], m_fc[2], m_dc[2];
   int m_prev;
   int nb[2]    = '{4, 3};
   int cmod[2]  = '{16, 65536};

   function automatic int next_write(int w, int nr, int n);
      for (int k = 1; k <= n; k++) begin
         if ((w + k) % n != nr) return (w + k) % n;
      end
      return w;
   endfunction

   function automatic longint base_of(int idx);
      return (longint'(idx) * 64'd2073600) % 64'd16777216;
   endfunction

   task automatic model_step();
      int nr;
      bit edge_seen;
      edge_seen = vs && !m_prev;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_ph[d] = 0; m_w[d] = 0; m_r[d] = nb[d] - 1; m_rv[d] = 0; m_fc[d] = 0; m_dc[d] = 0;
         end else if (m_ph[d] == 0) begin
            if (edge_seen) m_ph[d] = 1;
         end else if (m_ph[d] == 1) begin
            if (ack) m_ph[d] = 2;
            if (edge_seen && m_dc[d] < cmod[d] - 1) m_dc[d]++;
         end else if (edge_seen) begin
            nr = frz ? m_r[d] : m_w[d];
            m_w[d] = next_write(m_w[d], nr, nb[d]);
            m_r[d] = nr;
            m_fc[d] = (m_fc[d] + 1) % cmod[d];
            if (!(frz && m_rv[d] == 0)) m_rv[d] = 1;
            m_ph[d] = 1;
         end
      end
      m_prev = rst ? 0 : int'(vs);
   endtask

   task automatic cmp(string name, longint act, longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      cmp("a.write_req", a_req, longint'(m_ph[0] == 1 && !rst));
      cmp("a.write_idx", a_w, m_w[0]);
      cmp("a.read_idx", a_r, m_r[0]);
      cmp("a.write_base", a_wba, base_of(m_w[0]));
      cmp("a.read_base", a_rba, base_of(m_r[0]));
      cmp("a.read_valid", a_rv, m_rv[0]);
      cmp("a.frame_count", a_fc, m_fc[0]);
      cmp("a.drop_count", a_dc, m_dc[0]);
      cmp("b.write_req", b_req, longint'(m_ph[1] == 1 && !rst));
      cmp("b.write_idx", b_w, m_w[1]);
      cmp("b.read_idx", b_r, m_r[1]);
      cmp("b.write_base", b_wba, base_of(m_w[1]));
      cmp("b.read_base", b_rba, base_of(m_r[1]));
      cmp("b.read_valid", b_rv, m_rv[1]);
      cmp("b.frame_count", b_fc, m_fc[1]);
      cmp("b.drop_count", b_dc, m_dc[1]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic pulse();
      vs = 1'b1; tick();
      vs = 1'b0; tick();
   endtask

   task automatic ack2();
      tick(); tick();
      ack = 1'b1; tick();
      ack = 1'b0; tick();
   endtask

   task automatic do_reset();
      rst = 1'b1; tick();
      rst = 1'b0;
   endtask

   typedef struct {
      bit rst, vs, ack, frz;
      bit e_req;
      int e_w, e_r, e_fc, e_dc;
      bit e_rv;
      int e_wba;
   } vec_t;

   vec_t tbl[17];
   int   wseq[7]  = '{0, 1, 2, 0, 1, 2, 0};
   int   fwseq[5] = '{2, 3, 0, 2, 3};

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 0, 1, 0, 3, 0, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 0, 0, 0, 3, 0, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0};
      tbl[5]  = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 2073600};
      tbl[6]  = '{0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 2073600};
      tbl[7]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 2073600};
      tbl[8]  = '{0, 1, 0, 0, 1, 2, 1, 2, 0, 1, 4147200};
      tbl[9]  = '{0, 0, 1, 0, 0, 2, 1, 2, 0, 1, 4147200};
      tbl[10] = '{0, 1, 0, 0, 1, 3, 2, 3, 0, 1, 6220800};
      tbl[11] = '{0, 0, 0, 0, 1, 3, 2, 3, 0, 1, 6220800};
      tbl[12] = '{0, 1, 0, 0, 1, 3, 2, 3, 1, 1, 6220800};
      tbl[13] = '{0, 0, 0, 0, 1, 3, 2, 3, 1, 1, 6220800};
      tbl[14] = '{0, 1, 1, 0, 0, 3, 2, 3, 2, 1, 6220800};
      tbl[15] = '{0, 1, 0, 0, 0, 3, 2, 3, 2, 1, 6220800};
      tbl[16] = '{1, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0};

      rst = 1'b1; vs = 1'b0; frz = 1'b0; ack = 1'b0; m_prev = 0;
      tick(); tick();

      // Directed table on the 4-buffer instance.
      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst; vs = tbl[i].vs; ack = tbl[i].ack; frz = tbl[i].frz;
         tick();
         cmp($sformatf("tbl%0d.req", i), a_req, tbl[i].e_req);
         cmp($sformatf("tbl%0d.w", i), a_w, tbl[i].e_w);
         cmp($sformatf("tbl%0d.r", i), a_r, tbl[i].e_r);
         cmp($sformatf("tbl%0d.fc", i), a_fc, tbl[i].e_fc);
         cmp($sformatf("tbl%0d.dc", i), a_dc, tbl[i].e_dc);
         cmp($sformatf("tbl%0d.rv", i), a_rv, tbl[i].e_rv);
         cmp($sformatf("tbl%0d.wba", i), a_wba, tbl[i].e_wba);
      end
      rst = 1'b0; vs = 1'b0; ack = 1'b0; frz = 1'b0;

      // Three-buffer rotation.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         pulse(); ack2();
         cmp($sformatf("b.wseq%0d", i), b_w, wseq[i]);
         if (i > 0) cmp($sformatf("b.rtrail%0d", i), b_r, wseq[i-1]);
      end

      // Freeze holds the displayed buffer while writes skip it.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         pulse(); ack2();
      end
      cmp("a.prefrz_r", a_r, 1);
      frz = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmp($sformatf("a.frz_w%0d", i), a_w, fwseq[i]);
         pulse(); ack2();
         cmp($sformatf("a.frz_r%0d", i), a_r, 1);
      end
      frz = 1'b0;
      pulse();
      cmp("a.unfrz_r", a_r, 0);

      // Withheld ack, then coincident edge and ack.
      do_reset();
      pulse();
      for (int i = 0; i < 3; i++) pulse();
      cmp("a.drop3", a_dc, 3);
      cmp("a.drop3_req", a_req, 1);
      cmp("a.drop3_w", a_w, 0);
      cmp("a.drop3_r", a_r, 3);
      ack = 1'b1; tick(); ack = 1'b0; tick();
      cmp("a.ack_active_req", a_req, 0);
      pulse();
      vs = 1'b1; ack = 1'b1; tick();
      cmp("a.coinc_req", a_req, 0);
      cmp("a.coinc_dc", a_dc, 4);
      vs = 1'b0; ack = 1'b0; tick();

      // Counter saturation and wrap.
      do_reset();
      pulse();
      for (int i = 0; i < 20; i++) pulse();
      cmp("a.drop_sat", a_dc, 15);
      cmp("b.drop20", b_dc, 20);
      do_reset();
      pulse(); ack2();
      for (int i = 0; i < 17; i++) begin
         pulse(); ack2();
      end
      cmp("a.fc_wrap", a_fc, 1);
      cmp("b.fc17", b_fc, 17);

      // Reset while requesting and while active.
      do_reset();
      pulse();
      rst = 1'b1; #1;
      cmp("a.rst_req_now", a_req, 0);
      cmp("b.rst_req_now", b_req, 0);
      tick(); rst = 1'b0;
      cmp("a.rst_req_w", a_w, 0);
      pulse(); ack2(); pulse(); ack2();
      rst = 1'b1; tick(); rst = 1'b0;
      cmp("a.rst_act_w", a_w, 0);
      cmp("a.rst_act_r", a_r, 3);
      cmp("a.rst_act_fc", a_fc, 0);
      cmp("a.rst_act_rv", a_rv, 0);

      // Randomised traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) vs = ~vs;
         ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 39) == 0) frz = ~frz;
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/frame_buffer_index_gen.md
Name: frame_buffer_index_gen

Overview:
- Parametrised successor to the fixed 4-buffer CMOS write-request/index generator.
- Sits between the CMOS capture front end and frame_read_write, all in one clock domain.
- Per frame, it issues a write request with a handshake and selects the write and read buffer indices out of NUM_BUFS buffers.
- Outputs the matching SDRAM base addresses, supports a freeze (hold displayed frame) mode, and counts completed and dropped frames.

Parameters:
NUM_BUFS, 4, number of frame buffers; legal range 2..16
IDX_W, 2, index width; must satisfy 2**IDX_W >= NUM_BUFS
ADDR_W, 24, SDRAM address width
BASE_ADDR, 0, address of buffer 0
FRAME_STRIDE, 2073600, address distance between consecutive buffers
CNT_W, 16, width of frame_count and drop_count

Ports:
clk  in  1  system clock (CMOS pixel clock domain)
rst  in  1  synchronous reset, active-high
frame_vsync  in  1  frame sync, active-high level; a rising edge marks frame start
freeze  in  1  1 = hold read index (displayed frame); writes continue
write_req  out  1  frame write request to frame_read_write
write_req_ack  in  1  acknowledge of write_req
write_addr_index  out  IDX_W  buffer currently being written
read_addr_index  out  IDX_W  buffer the display reads
write_base_addr  out  ADDR_W  BASE_ADDR + write_addr_index*FRAME_STRIDE
read_base_addr  out  ADDR_W  BASE_ADDR + read_addr_index*FRAME_STRIDE
read_valid  out  1  1 once at least one complete frame exists
frame_count  out  CNT_W  completed frames, wraps modulo 2**CNT_W
drop_count  out  CNT_W  dropped frame starts, saturates at all-ones

Behaviour:
Reset values:
- write_req=0, write_addr_index=0, read_addr_index=NUM_BUFS-1, read_valid=0, counters=0.
- State=IDLE; the vsync edge register is cleared to 0.

Edge detection:
- frame_vsync is registered once.
- edge = frame_vsync & ~vsync_d.
- An edge is acted on in the cycle it is detected.

States:
- IDLE (no frame in progress), REQ (write_req=1, awaiting ack), ACTIVE (frame being written).

IDLE:
- On edge: write_req<=1, go to REQ. Indices are unchanged; the first frame goes to buffer 0.

REQ:
- write_req held at 1 until write_req_ack is sampled 1.
- On ack: write_req<=0 next cycle, go to ACTIVE.
- Edge without ack: frame start dropped; drop_count+1 (saturating); indices unchanged; stay in REQ.
- Edge and ack in the same cycle: ack wins (go to ACTIVE, write_req<=0); the edge is counted as dropped.

ACTIVE:
- On edge, the frame in write_addr_index (w) is complete:
  - new_read = freeze ? read_addr_index : w
  - next_w = (w+1) mod NUM_BUFS; if next_w == new_read then next_w = (w+2) mod NUM_BUFS
  - read_addr_index<=new_read, write_addr_index<=next_w
  - frame_count+1; read_valid<=1 unless freeze is set and read_valid is 0
  - write_req<=1, go to REQ
- write_req_ack while in ACTIVE or IDLE is ignored.

Index rules:
- The write index never equals the read index after the first completed frame.
- Wrap-around is modulo NUM_BUFS, never 2**IDX_W.
- Implementation must not use % on a non-power-of-two; use a compare-and-reset.
- freeze takes effect at the next completion edge only; a freeze toggle mid-frame does not alter the indices.

Base addresses:
- Combinational from the index registers, so there is zero latency relative to the indices.
- Product computed in ADDR_W bits; higher bits truncated.

Reset mid-operation:
- Everything returns to reset values on the next clk edge, regardless of state.
- A pending write_req is withdrawn immediately.

Test Plan:
- Reset, NUM_BUFS=4, 3 vsync pulses each acked 2 cycles after write_req:
  - write index goes 0→1→2, read index 3→0→1, frame_count=2, read_valid=1 after the 2nd edge.
  - write_base_addr for index 2 = 4147200.
- NUM_BUFS=3, 7 acked frames:
  - write index sequence 0,1,2,0,1,2,0; read always trails the write index by one; indices never equal 3.
- Freeze asserted after frame 2 (read=1), 5 more frames:
  - read_addr_index stays 1; write cycles 2,3,0,2,3, skipping 1.
  - Freeze released: next edge gives read = the last written buffer.
- Ack withheld, 3 vsync edges:
  - drop_count=3, write_req held at 1, indices unchanged.
  - Ack then gives ACTIVE.
  - Edge coincident with ack: ACTIVE entered, drop_count+1.
- CNT_W=4, 20 unacked edges: drop_count saturates at 15. 17 completed frames: frame_count wraps to 1.
- rst asserted in REQ and in ACTIVE: next cycle all outputs at reset values; write_req=0 in the same cycle rst is sampled.
